mesm6_membus_arbiter: RTL and testbench

//  Shares one single-ported memory between the CPU instruction bus (ibus) and data bus (dbus).

---
 rtl/mesm6_arb_pkg.sv | 20 ++
 rtl/mesm6_arb_timer.sv | 30 +++
 rtl/mesm6_membus_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mesm6_membus_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mesm6_arb_pkg.sv
// Shared types and default widths for the mesm6 memory bus arbiter.
package mesm6_arb_pkg;

  localparam int ARB_AW = 15;
  localparam int ARB_DW = 48;

  typedef enum logic [2:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

endpackage

// File: rtl/mesm6_arb_timer.sv
// WAIT-state watchdog for the mesm6 arbiter.
// Counts consecutive WAIT cycles and flags expiry so that the strobe has been
// held for exactly TIMEOUT cycles (one GRANT cycle plus TIMEOUT-1 WAIT cycles).
module mesm6_arb_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run_i,
  output logic expired_o
);

  localparam int TW = $clog2(TIMEOUT);

  logic [TW-1:0] cnt_q;

  assign expired_o = run_i && (cnt_q == TW'(TIMEOUT - 2));

  // Clear outside WAIT, count up while waiting, freeze once expired.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (!run_i) begin
      cnt_q <= '0;
    end else if (!expired_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mesm6_membus_arbiter.sv
// Shares one single-ported memory between the mesm6 instruction and data buses.
// Data bus has priority, limited to DBUS_BURST consecutive grants while an
// instruction fetch is pending.
// Optional watchdog: define MESM6_ARB_TIMEOUT_EN to abort accesses whose
// mem_done never arrives (bus_error pulses with the done); otherwise bus_error is 0.
//
// Request/done handshake: a request is a level held by the core until the
// matching done pulse (one cycle). Once granted, an access always runs to
// completion and its done is always pulsed, even if the request is withdrawn.
// Requests are not sampled in RESP; the core may change them from then on.
module mesm6_membus_arbiter
  import mesm6_arb_pkg::*;
#(
  parameter int AW         = ARB_AW,
  parameter int DW         = ARB_DW,
  parameter int DBUS_BURST = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ibus_fetch,
  input  logic [AW-1:0] ibus_addr,
  output logic [DW-1:0] ibus_input,
  output logic          ibus_done,
  input  logic          dbus_read,
  input  logic          dbus_write,
  input  logic [AW-1:0] dbus_addr,
  input  logic [DW-1:0] dbus_output,
  output logic [DW-1:0] dbus_input,
  output logic          dbus_done,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_done,
  output logic          bus_error,
  output arb_state_t    dbg_state
);

  localparam int BW = $clog2(DBUS_BURST + 1);

  arb_state_t    state_q;
  owner_t        owner_q;
  logic [BW-1:0] burst_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] irdata_q;
  logic [DW-1:0] drdata_q;
  logic          rd_q;
  logic          wr_q;
  logic          idone_q;
  logic          ddone_q;
  logic          err_q;

  logic          dbus_pend;
  logic          dbus_wins;
  logic          timeout_hit;

  assign dbus_pend = dbus_read | dbus_write;
  assign dbus_wins = dbus_pend && ((burst_q < BW'(DBUS_BURST)) || !ibus_fetch);

`ifdef MESM6_ARB_TIMEOUT_EN
  mesm6_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .run_i     (state_q == WAIT),
    .expired_o (timeout_hit)
  );
`else
  // TIMEOUT only matters when the watchdog is built.
  localparam bit TIMEOUT_OK = (TIMEOUT >= 2);
  assign timeout_hit = 1'b0 && TIMEOUT_OK;
`endif

  // Arbitration FSM; every output is a register written here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      owner_q  <= OWN_I;
      burst_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      idone_q  <= 1'b0;
      ddone_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      idone_q <= 1'b0;
      ddone_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!ibus_fetch) begin
            burst_q <= '0;
          end
          if (dbus_wins) begin
            state_q <= GRANT_D;
            owner_q <= OWN_D;
            addr_q  <= dbus_addr;
            wdata_q <= dbus_output;
            rd_q    <= ~dbus_write;
            wr_q    <= dbus_write;
            if (ibus_fetch) begin
              burst_q <= burst_q + 1'b1;
            end
          end else if (ibus_fetch) begin
            state_q <= GRANT_I;
            owner_q <= OWN_I;
            addr_q  <= ibus_addr;
            rd_q    <= 1'b1;
            wr_q    <= 1'b0;
            burst_q <= '0;
          end
        end
        GRANT_I, GRANT_D: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (mem_done) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            state_q <= RESP;
            if (owner_q == OWN_I) begin
              irdata_q <= mem_rdata;
              idone_q  <= 1'b1;
            end else begin
              if (!wr_q) begin
                drdata_q <= mem_rdata;
              end
              ddone_q <= 1'b1;
            end
          end else if (timeout_hit) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b1;
            state_q <= RESP;
            if (owner_q == OWN_I) begin
              irdata_q <= '0;
              idone_q  <= 1'b1;
            end else begin
              drdata_q <= '0;
              ddone_q  <= 1'b1;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ibus_input = irdata_q;
  assign ibus_done  = idone_q;
  assign dbus_input = drdata_q;
  assign dbus_done  = ddone_q;
  assign mem_read   = rd_q;
  assign mem_write  = wr_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign bus_error  = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mesm6_membus_arbiter.sv
// Self-checking bench for mesm6_membus_arbiter (optional MESM6_ARB_TIMEOUT_EN section).
module tb_mesm6_membus_arbiter;
  import mesm6_arb_pkg::*;

  localparam int AW  = 15;
  localparam int DW  = 48;
  localparam int BUR = 4;
  localparam int TMO = 8;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;

  logic          clk;
  logic          reset_n;
  logic          ibus_fetch;
  logic [AW-1:0] ibus_addr;
  logic [DW-1:0] ibus_input;
  logic          ibus_done;
  logic          dbus_read;
  logic          dbus_write;
  logic [AW-1:0] dbus_addr;
  logic [DW-1:0] dbus_output;
  logic [DW-1:0] dbus_input;
  logic          dbus_done;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_done;
  logic          bus_error;
  arb_state_t    dbg_state;

  mesm6_membus_arbiter #(
    .AW         (AW),
    .DW         (DW),
    .DBUS_BURST (BUR),
    .TIMEOUT    (TMO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ibus_fetch  (ibus_fetch),
    .ibus_addr   (ibus_addr),
    .ibus_input  (ibus_input),
    .ibus_done   (ibus_done),
    .dbus_read   (dbus_read),
    .dbus_write  (dbus_write),
    .dbus_addr   (dbus_addr),
    .dbus_output (dbus_output),
    .dbus_input  (dbus_input),
    .dbus_done   (dbus_done),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_done    (mem_done),
    .bus_error   (bus_error),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  acc_t          exp_acc_q[$];
  logic [DW-1:0] exp_i_q[$];
  logic [DW-1:0] exp_d_q[$];
  logic [DW-1:0] exp_d_last = '0;
  bit            exp_err    = 1'b0;

  logic [DW-1:0] mem_arr [int];
  int  mem_lat  = 2;
  bit  mem_hang = 1'b0;
  int  last_strobe_cyc = 0;
  int  strobe_len = 0;
  acc_t rsp_a;
  bit   rsp_abort;
  int   dcs [6];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_get(input logic [AW-1:0] a);
    if (mem_arr.exists(int'(a))) return mem_arr[int'(a)];
    return {a, 3'b101, a ^ 15'h5A5A, a ^ 15'h1234};
  endfunction

  task automatic expect_read_i(input logic [AW-1:0] a);
    exp_acc_q.push_back('{wr: 1'b0, addr: a, wdata: '0});
    exp_i_q.push_back(mem_get(a));
  endtask

  task automatic expect_read_d(input logic [AW-1:0] a);
    exp_acc_q.push_back('{wr: 1'b0, addr: a, wdata: '0});
    exp_d_last = mem_get(a);
    exp_d_q.push_back(exp_d_last);
  endtask

  task automatic expect_write_d(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_acc_q.push_back('{wr: 1'b1, addr: a, wdata: d});
    exp_d_q.push_back(exp_d_last);
  endtask

  // ---------------- memory responder ----------------
  initial begin
    mem_done  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset_n && (mem_read || mem_write)) begin
        last_strobe_cyc = cyc;
        if (exp_acc_q.size() == 0) begin
          chk("acc_unexpected", 1, 0);
        end else begin
          rsp_a = exp_acc_q.pop_front();
          chk("acc_wr", mem_write, rsp_a.wr);
          chk("acc_rd", mem_read, !rsp_a.wr);
          chk("acc_addr", mem_addr, rsp_a.addr);
          if (rsp_a.wr) chk("acc_wdata", mem_wdata, rsp_a.wdata);
        end
        rsp_abort  = 1'b0;
        strobe_len = 1;
        if (mem_hang) begin
          for (int i = 0; i < 200 && (mem_read || mem_write) && reset_n; i++) begin
            @(negedge clk);
            if (mem_read || mem_write) strobe_len++;
          end
        end else begin
          for (int i = 0; i < mem_lat; i++) begin
            @(negedge clk);
            if (!reset_n) begin
              rsp_abort = 1'b1;
              break;
            end
          end
          if (!rsp_abort) begin
            chk("strobe_held", mem_read | mem_write, 1);
            mem_rdata = mem_get(mem_addr);
            if (mem_write) mem_arr[int'(mem_addr)] = mem_wdata;
            mem_done = 1'b1;
            @(negedge clk);
            mem_done = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (ibus_done) begin
        if (exp_i_q.size() == 0) chk("ibus_done_unexp", 1, 0);
        else chk("ibus_data", ibus_input, exp_i_q.pop_front());
      end
      if (dbus_done) begin
        if (exp_d_q.size() == 0) chk("dbus_done_unexp", 1, 0);
        else chk("dbus_data", dbus_input, exp_d_q.pop_front());
      end
`ifdef MESM6_ARB_TIMEOUT_EN
      if (ibus_done || dbus_done) chk("bus_error", bus_error, exp_err);
      else if (bus_error) chk("bus_error_stray", bus_error, 0);
`else
      if (bus_error) chk("bus_error_tied", bus_error, 0);
`endif
    end
  end

  // ---------------- drivers ----------------
  task automatic ibus_op(input logic [AW-1:0] a, output int done_cyc);
    ibus_fetch = 1'b1;
    ibus_addr  = a;
    done_cyc   = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ibus_done) begin
        done_cyc = cyc;
        break;
      end
    end
    if (done_cyc < 0) chk("ibus_timeout", 0, 1);
    ibus_fetch = 1'b0;
  endtask

  task automatic dbus_op(input logic wr, input logic rd, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output int done_cyc);
    dbus_write  = wr;
    dbus_read   = rd;
    dbus_addr   = a;
    dbus_output = d;
    done_cyc    = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dbus_done) begin
        done_cyc = cyc;
        break;
      end
    end
    if (done_cyc < 0) chk("dbus_timeout", 0, 1);
    dbus_write = 1'b0;
    dbus_read  = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    int t0;
    int dc;
    int dci;
    int dcd;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    int op;

    reset_n     = 1'b0;
    ibus_fetch  = 1'b0;
    ibus_addr   = '0;
    dbus_read   = 1'b0;
    dbus_write  = 1'b0;
    dbus_addr   = '0;
    dbus_output = '0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_ibus_done", ibus_done, 0);
    chk("rst_dbus_done", dbus_done, 0);
    chk("rst_strobes", {mem_read, mem_write}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_inputs", {ibus_input, dbus_input}, 0);
    chk("rst_state", dbg_state, IDLE);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single fetch, latency
    mem_arr[int'(15'o100)] = 48'h123456789ABC;
    mem_lat = 2;
    expect_read_i(15'o100);
    t0 = cyc;
    ibus_op(15'o100, dc);
    chk("t1_strobe_cyc", last_strobe_cyc - t0, 1);
    chk("t1_done_cyc", dc - t0, 4);
    chk("t1_ibus_input", ibus_input, 48'h123456789ABC);
    repeat (2) @(negedge clk);

    // 2: simultaneous requests, dbus first, ibus right after
    mem_lat = 1;
    expect_read_d(15'h0123);
    expect_read_i(15'h0456);
    fork
      ibus_op(15'h0456, dci);
      dbus_op(1'b0, 1'b1, 15'h0123, '0, dcd);
    join
    chk("t2_dbus_first", dcd < dci, 1);
    chk("t2_ibus_follows", dci - dcd, 4);
    repeat (2) @(negedge clk);

    // 3: burst limit
    mem_lat = $urandom_range(1, 3);
    for (int k = 0; k < 4; k++) expect_read_d(15'h0200 + 15'(k));
    expect_read_i(15'h0300);
    for (int k = 4; k < 6; k++) expect_read_d(15'h0200 + 15'(k));
    fork
      ibus_op(15'h0300, dci);
      begin
        for (int k = 0; k < 6; k++) dbus_op(1'b0, 1'b1, 15'h0200 + 15'(k), '0, dcs[k]);
      end
    join
    chk("t3_i_after_d3", dci > dcs[3], 1);
    chk("t3_i_before_d4", dci < dcs[4], 1);
    repeat (2) @(negedge clk);

    // 4: write leaves dbus_input, then read back; read+write means write
    mem_lat = 3;
    expect_write_d(15'o7777, 48'hFFFF00000001);
    dbus_op(1'b1, 1'b0, 15'o7777, 48'hFFFF00000001, dc);
    exp_acc_q.push_back('{wr: 1'b0, addr: 15'o7777, wdata: '0});
    exp_d_q.push_back(48'hFFFF00000001);
    exp_d_last = 48'hFFFF00000001;
    dbus_op(1'b0, 1'b1, 15'o7777, '0, dc);
    expect_write_d(15'h0042, 48'hA5A5_0000_5A5A);
    dbus_op(1'b1, 1'b1, 15'h0042, 48'hA5A5_0000_5A5A, dc);
    chk("t4_rw_unchanged", dbus_input, 48'hFFFF00000001);
    repeat (2) @(negedge clk);

    // 5: reset in WAIT
    mem_lat = 20;
    exp_acc_q.push_back('{wr: 1'b0, addr: 15'h0055, wdata: '0});
    dbus_read = 1'b1;
    dbus_addr = 15'h0055;
    dc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_read) begin
        dc = cyc;
        break;
      end
    end
    chk("t5_strobe_seen", dc >= 0, 1);
    repeat (2) @(negedge clk);
    chk("t5_in_wait", dbg_state, WAIT);
    #1 reset_n = 1'b0;
    #1;
    chk("t5_rst_strobes", {mem_read, mem_write}, 0);
    chk("t5_rst_addr", mem_addr, 0);
    chk("t5_rst_inputs", {ibus_input, dbus_input}, 0);
    chk("t5_rst_state", dbg_state, IDLE);
    dbus_read = 1'b0;
    repeat (3) @(negedge clk);
    reset_n    = 1'b1;
    exp_d_last = '0;
    repeat (2) @(negedge clk);
    mem_lat = 2;
    expect_read_d(15'h0056);
    dbus_op(1'b0, 1'b1, 15'h0056, '0, dc);

    // 6: random sequential traffic
    for (int n = 0; n < 12; n++) begin
      mem_lat = $urandom_range(1, 4);
      op = $urandom_range(0, 2);
      ra = 15'($urandom_range(0, 32767));
      rd = {16'($urandom), 32'($urandom)};
      if (op == 0) begin
        expect_read_i(ra);
        ibus_op(ra, dc);
      end else if (op == 1) begin
        expect_read_d(ra);
        dbus_op(1'b0, 1'b1, ra, '0, dc);
      end else begin
        expect_write_d(ra, rd);
        dbus_op(1'b1, 1'b0, ra, rd, dc);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

`ifdef MESM6_ARB_TIMEOUT_EN
    // 7: timeout
    mem_hang = 1'b1;
    exp_err  = 1'b1;
    exp_acc_q.push_back('{wr: 1'b0, addr: 15'h0777, wdata: '0});
    exp_d_q.push_back('0);
    dbus_op(1'b0, 1'b1, 15'h0777, '0, dc);
    @(negedge clk);
    chk("t7_strobe_len", strobe_len, TMO);
    chk("t7_dbus_input", dbus_input, 0);
    mem_hang   = 1'b0;
    exp_err    = 1'b0;
    exp_d_last = '0;
`endif

    repeat (4) @(negedge clk);
    chk("acc_q_empty", exp_acc_q.size(), 0);
    chk("ibus_q_empty", exp_i_q.size(), 0);
    chk("dbus_q_empty", exp_d_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
